// File: rtl/bn_stream_mux_arb_if.sv
// Stream mux handshake bundle: N input channels in, one registered beat out.
// master drives the channel inputs and out_ready; slave is the mux itself.
interface bn_stream_mux_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
);
  localparam int N = 2**SEL_WIDTH;

  logic [N*DATA_WIDTH-1:0] in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_last;
  logic [N-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_WIDTH-1:0]    out_sel;
  logic                    out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_sel, out_last
  );
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_sel, out_last
  );
endinterface

// File: rtl/bn_stream_mux_arb.sv
// N:1 stream mux with round-robin or fixed-priority arbitration into a 1-deep output register.
// Define BN_STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module bn_stream_mux_arb_lane (
  input  logic valid_i,
  input  logic allow_i,
  input  logic gnt_i,
  input  logic load_en_i,
  output logic req_o,
  output logic ready_o
);
  assign req_o   = valid_i & allow_i;
  assign ready_o = gnt_i & load_en_i;
endmodule

module bn_stream_mux_arb #(
  parameter int DATA_WIDTH    = 8,
  parameter int SEL_WIDTH     = 2,
  parameter int PRIORITY_MODE = 0
) (
  input logic                clk_i,
  input logic                rst_i,
  bn_stream_mux_arb_if.slave bus
);
  localparam int N = 2**SEL_WIDTH;

  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  last_q, last_d;

  logic [N-1:0]          allow, req, gnt, ready;
  logic [SEL_WIDTH-1:0]  win, idx;
  logic                  any_req, load_en, xfer, win_last;

  // Reset gating keeps in_ready low for the whole time rst_i is asserted.
  assign load_en = !rst_i && (!valid_q || bus.out_ready);
  assign xfer    = load_en && any_req;

`ifdef BN_STREAM_MUX_LOCK_EN
  logic                 lock_q, lock_d;
  logic [SEL_WIDTH-1:0] lock_ch_q, lock_ch_d;

  for (genvar g = 0; g < N; g++) begin : g_allow
    assign allow[g] = !lock_q || (lock_ch_q == SEL_WIDTH'(g));
  end

  // Pointer moves only when a packet completes so a locked packet does not skew fairness.
  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      if (win_last) begin
        lock_d = 1'b0;
        ptr_d  = win + 1'b1;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = win;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  assign allow = '1;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = win + 1'b1;
  end
`endif

  for (genvar g = 0; g < N; g++) begin : g_lane
    bn_stream_mux_arb_lane u_lane (
      .valid_i   (bus.in_valid[g]),
      .allow_i   (allow[g]),
      .gnt_i     (gnt[g]),
      .load_en_i (load_en),
      .req_o     (req[g]),
      .ready_o   (ready[g])
    );
  end
  assign bus.in_ready = ready;

  // Scan from the back of the search order so the earliest requester is written last.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (PRIORITY_MODE == 1) ? SEL_WIDTH'(off) : ptr_q + SEL_WIDTH'(off);
      if (req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
    gnt = '0;
    if (any_req) gnt[win] = 1'b1;
    win_last = bus.in_last[win];
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (load_en) begin
      valid_d = any_req;
      if (any_req) begin
        data_d = bus.in_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        sel_d  = win;
        last_d = win_last;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_bn_stream_mux_arb.sv
// Directed bench: one fixed-priority and one round-robin mux on a shared clock/reset.
// Lock-dependent expectations follow BN_STREAM_MUX_LOCK_EN.
module tb_bn_stream_mux_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bn_stream_mux_arb_if #(.DATA_WIDTH(8), .SEL_WIDTH(2)) f_if ();
  bn_stream_mux_arb_if #(.DATA_WIDTH(8), .SEL_WIDTH(2)) r_if ();

  bn_stream_mux_arb #(.DATA_WIDTH(8), .SEL_WIDTH(2), .PRIORITY_MODE(1)) u_fix (
    .clk_i (clk), .rst_i (rst), .bus (f_if)
  );
  bn_stream_mux_arb #(.DATA_WIDTH(8), .SEL_WIDTH(2), .PRIORITY_MODE(0)) u_rr (
    .clk_i (clk), .rst_i (rst), .bus (r_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_dat  [4];
  logic [3:0] lk_vld  [4];
  logic       lk_lst  [4];
  logic [3:0] lk_rdy  [4];
  logic [1:0] lk_sel  [4];
  logic       lk_last [4];

  initial begin
    rr_dat = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
`ifdef BN_STREAM_MUX_LOCK_EN
    lk_vld  = '{4'b0011, 4'b0011, 4'b0011, 4'b0010};
    lk_lst  = '{1'b0, 1'b0, 1'b1, 1'b0};
    lk_rdy  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    lk_sel  = '{2'd0, 2'd0, 2'd0, 2'd1};
    lk_last = '{1'b0, 1'b0, 1'b1, 1'b0};
`else
    lk_vld  = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
    lk_lst  = '{1'b0, 1'b0, 1'b0, 1'b0};
    lk_rdy  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    lk_sel  = '{2'd0, 2'd1, 2'd0, 2'd1};
    lk_last = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    f_if.in_data = '0; f_if.in_valid = 4'hF; f_if.in_last = '0; f_if.out_ready = 1'b1;
    r_if.in_data = '0; r_if.in_valid = 4'h0; r_if.in_last = '0; r_if.out_ready = 1'b1;

    // Reset state, with requests pending on the fixed mux
    #2;
    chk("rst_valid", 32'(f_if.out_valid), 32'd0);
    chk("rst_data",  32'(f_if.out_data),  32'h00);
    chk("rst_sel",   32'(f_if.out_sel),   32'd0);
    chk("rst_last",  32'(f_if.out_last),  32'd0);
    chk("rst_rdy",   32'(f_if.in_ready),  32'h0);
    #10 rst = 1'b0;
    f_if.in_valid = 4'h0;
    tick();

    // Fixed priority: ch1 beats ch3 until ch1 drops
    f_if.in_data  = {8'h33, 8'h00, 8'h11, 8'h00};
    f_if.in_valid = 4'b1010;
    #1 chk("fix_rdy", 32'(f_if.in_ready), 32'b0010);
    tick();
    chk("fix_valid", 32'(f_if.out_valid), 32'd1);
    chk("fix_data1", 32'(f_if.out_data),  32'h11);
    chk("fix_sel1",  32'(f_if.out_sel),   32'd1);
    tick();
    chk("fix_sel1b", 32'(f_if.out_sel),   32'd1);
    f_if.in_valid = 4'b1000;
    #1 chk("fix_rdy3", 32'(f_if.in_ready), 32'b1000);
    tick();
    chk("fix_data3", 32'(f_if.out_data),  32'h33);
    chk("fix_sel3",  32'(f_if.out_sel),   32'd3);
    f_if.in_valid = 4'b0000;
    #1 chk("idle_rdy0", 32'(f_if.in_ready), 32'h0);
    tick();
    chk("idle_valid", 32'(f_if.out_valid), 32'd0);
    chk("idle_rdy1",  32'(f_if.in_ready),  32'h0);

    // Round-robin rotation with all channels valid
    r_if.in_data  = {rr_dat[3], rr_dat[2], rr_dat[1], rr_dat[0]};
    r_if.in_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_sel%0d", k),  32'(r_if.out_sel),  32'(k % 4));
      chk($sformatf("rr_data%0d", k), 32'(r_if.out_data), 32'(rr_dat[k % 4]));
    end
    r_if.in_valid = 4'h0;
    tick();
    chk("rr_idle", 32'(r_if.out_valid), 32'd0);

    // Backpressure: held beat stable, other requests ignored until drained
    f_if.out_ready = 1'b0;
    f_if.in_data   = {8'h00, 8'h5A, 8'h00, 8'h00};
    f_if.in_valid  = 4'b0100;
    tick();
    chk("bp_load", 32'(f_if.out_data),  32'h5A);
    chk("bp_vld",  32'(f_if.out_valid), 32'd1);
    f_if.in_data  = {8'h00, 8'h66, 8'h00, 8'hC0};
    f_if.in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i),  32'(f_if.in_ready), 32'h0);
      chk($sformatf("bp_data%0d", i), 32'(f_if.out_data), 32'h5A);
      chk($sformatf("bp_sel%0d", i),  32'(f_if.out_sel),  32'd2);
      tick();
    end
    f_if.out_ready = 1'b1;
    #1 chk("bp_rdy_go", 32'(f_if.in_ready), 32'b0001);
    tick();
    chk("bp_next_data", 32'(f_if.out_data),  32'hC0);
    chk("bp_next_sel",  32'(f_if.out_sel),   32'd0);
    chk("bp_next_vld",  32'(f_if.out_valid), 32'd1);
    f_if.in_valid = 4'h0;
    tick();
    chk("bp_drain", 32'(f_if.out_valid), 32'd0);

    // Packet from ch0 competing with ch1 on the round-robin mux
    for (int c = 0; c < 4; c++) begin
      r_if.in_data  = {8'h00, 8'h00, 8'(8'h20 + c), 8'(8'h10 + c)};
      r_if.in_valid = lk_vld[c];
      r_if.in_last  = {3'b000, lk_lst[c]};
      #1 chk($sformatf("lk_rdy%0d", c), 32'(r_if.in_ready), 32'(lk_rdy[c]));
      tick();
      chk($sformatf("lk_sel%0d", c),  32'(r_if.out_sel),  32'(lk_sel[c]));
      chk($sformatf("lk_last%0d", c), 32'(r_if.out_last), 32'(lk_last[c]));
    end
    r_if.in_valid = 4'h0;
    r_if.in_last  = 4'h0;
    tick();
    chk("lk_idle", 32'(r_if.out_valid), 32'd0);

    // Asynchronous reset with a held beat, then first grant afterwards
    f_if.out_ready = 1'b0;
    f_if.in_data   = {8'h00, 8'h00, 8'h00, 8'h77};
    f_if.in_valid  = 4'b0001;
    tick();
    chk("ar_pre_data", 32'(f_if.out_data),  32'h77);
    chk("ar_pre_vld",  32'(f_if.out_valid), 32'd1);
    f_if.in_valid = 4'hF;
    r_if.in_valid = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("ar_vld",   32'(f_if.out_valid), 32'd0);
    chk("ar_data",  32'(f_if.out_data),  32'h00);
    chk("ar_rdy_f", 32'(f_if.in_ready),  32'h0);
    chk("ar_rdy_r", 32'(r_if.in_ready),  32'h0);
    #2 rst = 1'b0;
    f_if.out_ready = 1'b1;
    #1;
    chk("ar_post_rdy_r", 32'(r_if.in_ready), 32'b0001);
    chk("ar_post_rdy_f", 32'(f_if.in_ready), 32'b0001);
    tick();
    chk("ar_post_sel_r", 32'(r_if.out_sel),   32'd0);
    chk("ar_post_vld_r", 32'(r_if.out_valid), 32'd1);
    chk("ar_post_dat_f", 32'(f_if.out_data),  32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
